// File: rtl/oh_skidbuf.sv
// rtl/oh_skidbuf.sv - two-entry valid/ready register slice (skid buffer)
//
// Purpose:
//   Breaks ready/valid timing paths between an upstream producer and a
//   downstream register stage. out_valid, out_data and in_ready all come
//   straight from flops. Sustains one word per cycle and keeps strict FIFO order.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   in_valid   upstream word valid
//   in_data    upstream word (DW bits)
//   in_ready   slice can accept a word (registered)
//   out_valid  downstream word valid (registered)
//   out_data   downstream word (registered, main register)
//   out_ready  downstream accepts
//   level      occupancy 0..2 (the state encoding itself)

module oh_skidbuf #(
  parameter int DW = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  input  logic          out_ready,
  output logic [1:0]    level
);

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [DW-1:0]   main_q;
  logic [DW-1:0]   main_nxt;
  logic [DW-1:0]   skid_q;
  logic [DW-1:0]   skid_nxt;
  logic            out_valid_q;
  logic            in_ready_q;
  logic            in_xfer;
  logic            out_xfer;

  // Handshakes use the registered flags, so no input reaches an output
  // combinationally. in_valid gates the sample, keeping X data out of state.
  assign in_xfer  = in_valid & in_ready_q;
  assign out_xfer = out_valid_q & out_ready;

  always_comb begin
    state_nxt = state;
    main_nxt  = main_q;
    skid_nxt  = skid_q;
    case (state)
      EMPTY: begin
        if (in_xfer) begin
          main_nxt  = in_data;
          state_nxt = ONE;
        end
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          // Pass-through: new word replaces the departing one, skid untouched.
          main_nxt = in_data;
        end else if (in_xfer) begin
          skid_nxt  = in_data;
          state_nxt = TWO;
        end else if (out_xfer) begin
          state_nxt = EMPTY;
        end
      end
      TWO: begin
        // in_ready is low here, so only the drain side can move.
        if (out_xfer) begin
          main_nxt  = skid_q;
          state_nxt = ONE;
        end
      end
      default: begin
        state_nxt = EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state       <= state_nxt;
      main_q      <= main_nxt;
      skid_q      <= skid_nxt;
      // Flags are recomputed from the next state so they stay pure flops.
      out_valid_q <= (state_nxt != EMPTY);
      in_ready_q  <= (state_nxt != TWO);
    end
  end

  assign out_valid = out_valid_q;
  assign in_ready  = in_ready_q;
  assign out_data  = main_q;
  assign level     = state;

endmodule
